// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types, constants and the round-robin search helper
//               used by the FIFO write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Width of the per-grant beat counter
  localparam int BEAT_W = 8;

  // Widest requester vector the search helper handles
  localparam int PICK_MAX = 16;

  // Index of the first set bit of req, searching start, start+1, ... mod 16.
  // Callers zero-pad unused upper bits, so the mod-16 walk visits the live
  // requesters in the same order as a mod-NREQ walk would.
  function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] start);
    logic [3:0] res;
    logic [3:0] idx;
    logic       found;
    res   = start;
    found = 1'b0;
    for (int i = 0; i < PICK_MAX; i++) begin
      idx = start + 4'(i);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational rotating-priority picker. Returns the first
//               requester at or after start_i (with wrap) and whether any
//               requester is pending at all.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] start_i,
  output logic [$clog2(NREQ)-1:0] pick_o,
  output logic                    any_o
);

  localparam int IW = $clog2(NREQ);

  logic [15:0] w_req_pad;
  logic [3:0]  w_start_pad;
  logic [3:0]  w_pick;

  // Pad to the helper's fixed width and narrow the result back
  always_comb begin
    w_req_pad   = 16'(req_i);
    w_start_pad = 4'(start_i);
    w_pick      = rr_pick(w_req_pad, w_start_pad);
    pick_o      = IW'(w_pick);
    any_o       = |req_i;
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin arbiter sharing one FIFO write port among NREQ
//               producers, with bursts of up to MAX_BURST beats per grant
//               and full-flag backpressure.
//               Optional: FIFO_WR_ARBITER_STATS_EN adds a saturating 16-bit
//               stall_cnt output counting full-stalled grant cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         ack,
  input  logic                    full,
  output logic                    wr,
  output logic [DW-1:0]           w_data,
  output logic                    busy,
`ifdef FIFO_WR_ARBITER_STATS_EN
  output logic [15:0]             stall_cnt,
`endif
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int IW = $clog2(NREQ);
  // Beat count value at which the next beat closes the burst
  localparam logic [BEAT_W-1:0] c_last_beat = BEAT_W'(MAX_BURST - 1);

  arb_state_t        state_q;
  logic [IW-1:0]     owner_q;
  logic [IW-1:0]     last_q;
  logic [BEAT_W-1:0] beats_q;
  logic              busy_q;

  logic              w_grant;
  logic              w_own_req;
  logic              w_beat;
  logic              w_limit;
  logic              w_release;
  logic [NREQ-1:0]   w_own_bit;
  logic [NREQ-1:0]   w_pick_req;
  logic [IW-1:0]     w_start;
  logic [IW-1:0]     w_pick;
  logic              w_any;

  // Successor index with wrap at NREQ
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] x);
    return (x == IW'(NREQ - 1)) ? '0 : x + IW'(1);
  endfunction

  // Beat/release decode and picker inputs; a burst-limit release hides the
  // releasing owner so any other pending requester wins the next grant
  always_comb begin
    w_grant    = (state_q == GRANT);
    w_own_req  = req[owner_q];
    w_beat     = w_grant & w_own_req & ~full;
    w_limit    = w_beat & (beats_q == c_last_beat);
    w_release  = w_grant & (~w_own_req | w_limit);
    w_own_bit  = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    w_pick_req = w_limit ? (req & ~w_own_bit) : req;
    w_start    = w_grant ? next_idx(owner_q) : next_idx(last_q);
  end

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_i   (w_pick_req),
    .start_i (w_start),
    .pick_o  (w_pick),
    .any_o   (w_any)
  );

  // FIFO-side outputs; reset gates the strobe so an aborted beat is not acked
  always_comb begin
    wr     = w_beat & reset;
    ack    = wr ? w_own_bit : '0;
    w_data = req_data[owner_q*DW +: DW];
    busy   = busy_q;
    owner  = owner_q;
  end

  // Grant FSM: arbitration from IDLE, burst counting and release in GRANT
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(NREQ - 1);
      beats_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_any) begin
            state_q <= GRANT;
            busy_q  <= 1'b1;
            owner_q <= w_pick;
            beats_q <= '0;
          end
        end
        GRANT: begin
          if (w_release) begin
            last_q <= owner_q;
            if (w_any) begin
              owner_q <= w_pick;
              beats_q <= '0;
            end else if (w_limit) begin
              beats_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (w_beat) begin
            beats_q <= beats_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of grant cycles where the owner has data but the FIFO is full
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else if (w_grant && w_own_req && full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` write port among `NREQ` producers. Each producer presents a request and data word. The arbiter grants one owner at a time, for bursts of up to `MAX_BURST` beats, and forwards accepted beats to the FIFO `wr`/`w_data` inputs. It honours the FIFO `full` flag, so no beat is ever lost or duplicated. It sits between producer blocks and the `fifo` instance, in the same clock domain.

## Interface
- `NREQ`, 4 — number of requesters, 2..16
- `DW`, 8 — data width; matches the `fifo` `DW`
- `MAX_BURST`, 4 — maximum consecutive beats per grant, 1..255

- `clk`  in  1  — system clock; all logic on rising edge
- `reset`  in  1  — synchronous, active-low; the design resets on a rising `clk` while `reset`=0
- `req`  in  NREQ  — per-requester request; held high while data is valid
- `req_data`  in  NREQ*DW  — packed data; requester i occupies bits [i*DW +: DW]
- `ack`  out  NREQ  — one-hot; `ack[i]`=1 means requester i's word is written this cycle
- `full`  in  1  — FIFO full flag
- `wr`  out  1  — FIFO write strobe
- `w_data`  out  DW  — FIFO write data
- `busy`  out  1  — a grant is held (state GRANT)
- `owner`  out  $clog2(NREQ)  — index of the current owner; valid when `busy`=1

## Operation
- FSM states: IDLE, GRANT. Registers: `owner`, `last` (last owner, RR pointer), `beats` (8-bit).
- IDLE: if any `req`=1, pick the first set bit searching `last+1`, `last+2`, … with wrap mod NREQ. Load `owner`, clear `beats`, go to GRANT. Otherwise stay in IDLE.
- GRANT, combinational outputs:
  - `wr` = `req[owner]` & ~`full`
  - `w_data` = slice `owner` of `req_data`
  - `ack` = `wr` << `owner`
- GRANT, sequential:
  - a beat is a cycle with `wr`=1; on a beat, `beats`++.
  - Release when `req[owner]`=0, or when a beat makes `beats`=MAX_BURST.
  - On release: `last`←`owner`. If any `req` is set (evaluated without the releasing owner's bit when the release is due to a burst limit), go directly to GRANT with the RR pick from `owner+1`. Otherwise go to IDLE.
  - If no other requester is pending at a burst-limit release, the same owner is re-granted and `beats` is cleared.
- `full`=1 in GRANT: `wr`=0 and `ack`=0. The owner and `beats` are held and there is no timeout; a full stall never counts as a beat.
- Requesters must hold `req` and data stable until `ack`. Dropping `req` without `ack` withdraws the request.
- `w_data` when `wr`=0 is don't-care but must be driven (no X).

## Timing
- Reset values: state=IDLE, `owner`=0, `last`=NREQ-1 (so requester 0 is first after reset), `beats`=0, `busy`=0, `wr`=0, `ack`=0.
- Arbitration latency: 1 cycle from IDLE (req at cycle t gives first possible `ack` at t+1). 0 bubble cycles between back-to-back grants.
- Throughput: 1 beat/cycle while the owner's `req`=1 and `full`=0.
- `full` acts combinationally on `wr` in the same cycle.
- Simultaneous release and new request: handled by the RR pick at the same edge.
- `reset`=0 during a burst aborts it: `wr`=0 in the reset cycle, FSM returns to IDLE, and the pending beat is not acked.

## Configuration
- Macro: `FIFO_WR_ARBITER_STATS_EN`.
- Defined: adds output `stall_cnt` (16 bits, saturating). It increments each GRANT cycle with `req[owner]`=1 and `full`=1, and resets to 0.
- Undefined: no port, no counter. All other behaviour is identical.

## Structure
- Package `fifo_arb_pkg`:
  - `arb_state_t` enum {IDLE, GRANT}
  - `BEAT_W`=8
  - function `rr_pick(req, start)` returning the index of the first set bit.
- Sub-module `rr_picker`: combinational priority rotate, parameterised on `NREQ`. It is instantiated once and used for both IDLE and release picks.

## Test plan
- Single requester: `req`=4'b0100, `MAX_BURST`=4, `full`=0, req held 10 cycles → one IDLE cycle, then `ack[2]` on every following cycle. `owner`=2 throughout; `beats` wraps 4→re-grant with no bubble.
- Fairness: `req`=4'b1111 held, `MAX_BURST`=2 → `ack` order 0,0,1,1,2,2,3,3,0,… with no idle cycles.
- Backpressure: owner 1 mid-burst, `full`=1 for 3 cycles → `wr`=0 and `ack`=0 for those 3 cycles; the burst resumes with `beats` unchanged, and exactly `MAX_BURST` total acks.
- Early release: owner 0 drops `req` after 1 beat while `req[3]`=1 → next cycle `owner`=3 and `ack[3]`=1.
- Reset mid-burst: `reset`=0 during GRANT → next cycle `busy`=0, `wr`=0; after release, `req`=4'b1111 grants requester 0 first.
- Stats (macro defined): 5 full-stall cycles → `stall_cnt`=5. Forcing 70000 stall cycles → `stall_cnt`=16'hFFFF.
